// File: rtl/apb_periph_demux_pkg.sv
// Shared types and constants for the APB peripheral demux: FSM encoding,
// the default SoC peripheral map and the select-index width helper.
package apb_periph_demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Current SoC map: DEF_NB_SLV contiguous 4 KiB windows starting at DEF_RULE_BASE
    localparam int          DEF_NB_SLV    = 12;
    localparam logic [31:0] DEF_RULE_BASE = 32'h1A10_1000;
    localparam logic [31:0] DEF_RULE_SIZE = 32'h0000_1000;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Priority rule matcher: lowest index whose [start, end) window holds the address.
// Latency: combinational. Backpressure: none, pure decode.
// Empty or inverted windows (start >= end) can never satisfy both compares.
module apb_addr_decode #(
    parameter int NB_SLV     = 12,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_W      = 4
) (
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [NB_SLV*ADDR_WIDTH-1:0] start_addr,
    input  logic [NB_SLV*ADDR_WIDTH-1:0] end_addr,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Walk downwards so the lowest matching index is the one left standing
        for (int i = NB_SLV - 1; i >= 0; i--) begin
            if ((addr >= start_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (addr <  end_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_periph_demux.sv
// APB 1-to-NB_SLV peripheral demux with rule-table decode and error response on misses.
// Latency: zero-wait hit responds 3 cycles after upstream setup, miss after 1 cycle.
// Backpressure: one access in flight; upstream held until s_pready_o. Optional watchdog: APB_DEMUX_TIMEOUT_EN.
module apb_periph_demux
    import apb_periph_demux_pkg::*;
#(
    parameter int NB_SLV         = 12,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_SLV*ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLV*ADDR_WIDTH-1:0] end_addr_i,
    input  logic [ADDR_WIDTH-1:0]        s_paddr_i,
    input  logic [DATA_WIDTH-1:0]        s_pwdata_i,
    input  logic                         s_pwrite_i,
    input  logic                         s_psel_i,
    input  logic                         s_penable_i,
    output logic [DATA_WIDTH-1:0]        s_prdata_o,
    output logic                         s_pready_o,
    output logic                         s_pslverr_o,
    output logic [ADDR_WIDTH-1:0]        m_paddr_o,
    output logic [DATA_WIDTH-1:0]        m_pwdata_o,
    output logic                         m_pwrite_o,
    output logic [NB_SLV-1:0]            m_psel_o,
    output logic                         m_penable_o,
    input  logic [NB_SLV*DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_SLV-1:0]            m_pready_i,
    input  logic [NB_SLV-1:0]            m_pslverr_i,
    output logic [ADDR_WIDTH-1:0]        err_addr_o,
    output logic                         err_valid_o
);

    localparam int IDX_W = idx_width(NB_SLV);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    write_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   err_addr_q;

    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic                    sel_rdy;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    timeout;

    // Upstream is sampled only in IDLE on psel; the enable phase carries no extra information here
    logic unused_penable;
    assign unused_penable = s_penable_i;

    apb_addr_decode #(
        .NB_SLV     (NB_SLV),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr       (s_paddr_i),
        .start_addr (start_addr_i),
        .end_addr   (end_addr_i),
        .hit        (hit),
        .idx        (hit_idx)
    );

    assign sel_rdy   = m_pready_i[idx_q];
    assign sel_err   = m_pslverr_i[idx_q];
    assign sel_rdata = m_prdata_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_DEMUX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] to_cnt_q;

    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside ACCESS so every access starts counting from 0
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != ACCESS)) begin
            to_cnt_q <= '0;
        end else if (!sel_rdy) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_psel_i) state_d = hit ? SETUP : RESP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (sel_rdy || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_psel_i) begin
                        // A miss leaves the downstream-facing registers untouched
                        if (hit) begin
                            addr_q  <= s_paddr_i;
                            wdata_q <= s_pwdata_i;
                            write_q <= s_pwrite_i;
                            idx_q   <= hit_idx;
                        end else begin
                            rdata_q    <= '0;
                            err_q      <= 1'b1;
                            err_addr_q <= s_paddr_i;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_rdy) begin
                        err_q   <= sel_err;
                        rdata_q <= (write_q || sel_err) ? '0 : sel_rdata;
                        if (sel_err) err_addr_q <= addr_q;
                    end else if (timeout) begin
                        err_q      <= 1'b1;
                        rdata_q    <= '0;
                        err_addr_q <= addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_paddr_o   = addr_q;
    assign m_pwdata_o  = wdata_q;
    assign m_pwrite_o  = write_q;
    assign m_psel_o    = ((state_q == SETUP) || (state_q == ACCESS)) ? (NB_SLV'(1) << idx_q) : '0;
    assign m_penable_o = (state_q == ACCESS);

    assign s_pready_o  = (state_q == RESP);
    assign s_prdata_o  = (state_q == RESP) ? rdata_q : '0;
    assign s_pslverr_o = (state_q == RESP) && err_q;
    assign err_valid_o = (state_q == RESP) && err_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_apb_periph_demux.sv
// Bench for apb_periph_demux: directed scenarios plus randomized accesses scored against a rule-table model.
`timescale 1ns/1ps
module tb_apb_periph_demux;
    import apb_periph_demux_pkg::*;

    localparam int NB = DEF_NB_SLV;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic [NB-1:0][AW-1:0] rs, re;
    logic [AW-1:0]         s_paddr;
    logic [DW-1:0]         s_pwdata;
    logic                  s_pwrite, s_psel, s_penable;
    logic [DW-1:0]         s_prdata_o;
    logic                  s_pready_o, s_pslverr_o;
    logic [AW-1:0]         m_paddr_o;
    logic [DW-1:0]         m_pwdata_o;
    logic                  m_pwrite_o;
    logic [NB-1:0]         m_psel_o;
    logic                  m_penable_o;
    logic [NB-1:0][DW-1:0] sl_rdata;
    logic [NB-1:0]         sl_err;
    logic [NB-1:0]         m_pready;
    logic [AW-1:0]         err_addr_o;
    logic                  err_valid_o;

    int ws [NB];
    int ws_cur;
    int acc_cnt = 0;
    int n_tests = 0;
    int n_fail  = 0;
    logic [AW-1:0] exp_err_addr;

    apb_periph_demux #(
        .NB_SLV(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .start_addr_i(rs), .end_addr_i(re),
        .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_pwrite_i(s_pwrite),
        .s_psel_i(s_psel), .s_penable_i(s_penable),
        .s_prdata_o(s_prdata_o), .s_pready_o(s_pready_o), .s_pslverr_o(s_pslverr_o),
        .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_pwrite_o(m_pwrite_o),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o),
        .m_prdata_i(sl_rdata), .m_pready_i(m_pready), .m_pslverr_i(sl_err),
        .err_addr_o(err_addr_o), .err_valid_o(err_valid_o)
    );

    // Slave models: selected slave answers after ws[] wait states in ACCESS
    always_comb begin
        ws_cur = 0;
        for (int i = 0; i < NB; i++) if (m_psel_o[i]) ws_cur = ws[i];
    end
    assign m_pready = (m_penable_o && (acc_cnt >= ws_cur)) ? m_psel_o : '0;
    always @(posedge clk_i) acc_cnt <= (m_penable_o && (m_pready == '0)) ? acc_cnt + 1 : 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest-index window containing the address; -1 when nothing maps it
    function automatic int ref_idx(input logic [AW-1:0] a);
        for (int i = 0; i < NB; i++)
            if ((rs[i] < re[i]) && (a >= rs[i]) && (a < re[i])) return i;
        return -1;
    endfunction

    task automatic xfer(input string tag, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic wr);
        int idx, exp_lat, exp_pcyc, cyc, pcyc;
        bit seen, to, exp_err, quiet;
        logic [NB-1:0] psel_or, exp_psel;
        logic [DW-1:0] exp_rd, got_rd;
        logic [AW-1:0] got_addr, got_ea;
        logic [DW-1:0] got_wd;
        logic got_wr, got_err, got_ev;
        idx = ref_idx(a);
        to  = 1'b0;
`ifdef APB_DEMUX_TIMEOUT_EN
        if (idx >= 0 && ws[idx] >= TO) to = 1'b1;
`endif
        if (idx < 0) begin
            exp_err = 1'b1; exp_lat = 1; exp_pcyc = 0; exp_psel = '0;
        end else begin
            exp_err  = to || sl_err[idx];
            exp_lat  = to ? 2 + TO : 3 + ws[idx];
            exp_pcyc = to ? 1 + TO : 2 + ws[idx];
            exp_psel = NB'(1) << idx;
        end
        exp_rd = (exp_err || wr) ? '0 : sl_rdata[idx < 0 ? 0 : idx];
        if (exp_err) exp_err_addr = a;

        @(negedge clk_i);
        s_paddr = a; s_pwdata = wd; s_pwrite = wr; s_psel = 1'b1; s_penable = 1'b0;
        cyc = 0; pcyc = 0; seen = 1'b0; quiet = 1'b1; psel_or = '0;
        got_rd = '0; got_err = 1'b0; got_ev = 1'b0; got_ea = '0;
        got_addr = '0; got_wd = '0; got_wr = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            s_penable = 1'b1;
            if (m_psel_o != '0) begin
                if (pcyc == 0) begin
                    got_addr = m_paddr_o; got_wd = m_pwdata_o; got_wr = m_pwrite_o;
                end
                pcyc++;
            end
            psel_or |= m_psel_o;
            if (s_pready_o) begin
                seen = 1'b1;
                got_rd = s_prdata_o; got_err = s_pslverr_o;
                got_ev = err_valid_o; got_ea = err_addr_o;
            end else if (s_prdata_o != '0 || err_valid_o || s_pslverr_o) begin
                quiet = 1'b0;
            end
        end
        s_psel = 1'b0; s_penable = 1'b0;
        chk({tag, ".resp_seen"}, 64'(seen), 64'(1));
        chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, ".psel_set"}, 64'(psel_or), 64'(exp_psel));
        chk({tag, ".psel_cycles"}, 64'(pcyc), 64'(exp_pcyc));
        chk({tag, ".prdata"}, 64'(got_rd), 64'(exp_rd));
        chk({tag, ".pslverr"}, 64'(got_err), 64'(exp_err));
        chk({tag, ".err_valid"}, 64'(got_ev), 64'(exp_err));
        chk({tag, ".err_addr"}, 64'(got_ea), 64'(exp_err_addr));
        chk({tag, ".quiet_before_resp"}, 64'(quiet), 64'(1));
        if (idx >= 0) begin
            chk({tag, ".m_paddr"}, 64'(got_addr), 64'(a));
            chk({tag, ".m_pwdata"}, 64'(got_wd), 64'(wd));
            chk({tag, ".m_pwrite"}, 64'(got_wr), 64'(wr));
        end
        @(negedge clk_i);
        chk({tag, ".single_resp"}, 64'({s_pready_o, err_valid_o, s_prdata_o}), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".s_prdata"}, 64'(s_prdata_o), 64'(0));
        chk({tag, ".s_ctl"}, 64'({s_pready_o, s_pslverr_o, err_valid_o}), 64'(0));
        chk({tag, ".m_psel"}, 64'({m_psel_o, m_penable_o, m_pwrite_o}), 64'(0));
        chk({tag, ".m_paddr"}, 64'(m_paddr_o), 64'(0));
        chk({tag, ".m_pwdata"}, 64'(m_pwdata_o), 64'(0));
        chk({tag, ".err_addr"}, 64'(err_addr_o), 64'(0));
    endtask

    initial begin
        int k;
        logic [AW-1:0] a;
        rst_i = 1'b1;
        s_psel = 1'b0; s_penable = 1'b0; s_paddr = '0; s_pwdata = '0; s_pwrite = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rs[i] = DEF_RULE_BASE + AW'(i) * DEF_RULE_SIZE;
            re[i] = rs[i] + DEF_RULE_SIZE;
            ws[i] = 0;
            sl_rdata[i] = $urandom;
            sl_err[i] = 1'b0;
        end
        exp_err_addr = '0;
        repeat (3) @(negedge clk_i);
        chk_all_zero("reset");
        rst_i = 1'b0;

        sl_rdata[3] = 32'hCAFE_F00D;
        xfer("read_s3", 32'h1A10_4010, 32'h0, 1'b0);
        xfer("unmapped_wr", 32'h0000_0100, 32'h1234_5678, 1'b1);

        // Overlap: rule 2 and rule 5 share 0x1A10_2000; rule 1 empty, rule 6 inverted
        rs[1] = 32'h1A10_2000; re[1] = 32'h1A10_2000;
        rs[2] = 32'h1A10_2000; re[2] = 32'h1A10_2800;
        rs[5] = 32'h1A10_1800; re[5] = 32'h1A10_3000;
        rs[6] = 32'h1A10_9000; re[6] = 32'h1A10_8000;
        xfer("overlap", 32'h1A10_2000, 32'h0, 1'b0);
        xfer("end2_boundary", 32'h1A10_2800, 32'h0, 1'b0);
        xfer("inverted_rule", 32'h1A10_7800, 32'h0, 1'b0);
        xfer("end_of_map", 32'h1A10_D000, 32'h0, 1'b0);

        ws[7] = 5; sl_err[7] = 1'b1;
        xfer("s7_wait_err", 32'h1A10_8004, 32'h0, 1'b0);
        ws[9] = 2;
        xfer("s9_write", 32'h1A10_A0F0, 32'hA5A5_0F0F, 1'b1);

`ifdef APB_DEMUX_TIMEOUT_EN
        ws[4] = 1000;
        xfer("timeout", 32'h1A10_5000, 32'h0, 1'b0);
        ws[4] = TO - 1;
        xfer("ready_at_timeout", 32'h1A10_5004, 32'h0, 1'b0);
`endif

        // Reset in the middle of an ACCESS phase
        ws[4] = 1000;
        @(negedge clk_i);
        s_paddr = 32'h1A10_5010; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
        @(negedge clk_i);
        s_penable = 1'b1;
        @(negedge clk_i);
        chk("rst_mid.in_access", 64'({m_psel_o, m_penable_o}), 64'({NB'(1) << 4, 1'b1}));
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_all_zero("rst_mid");
        s_psel = 1'b0; s_penable = 1'b0;
        rst_i = 1'b0;
        exp_err_addr = '0;
        @(negedge clk_i);
        chk("rst_mid.no_resp", 64'({s_pready_o, m_psel_o}), 64'(0));
        ws[4] = 0;
        xfer("post_rst", 32'h1A10_5010, 32'h0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, NB - 1);
            ws[k] = $urandom_range(0, 4);
            sl_err[k] = ($urandom_range(0, 3) == 0);
            sl_rdata[k] = $urandom;
            case ($urandom_range(0, 3))
                0:       a = rs[k] + AW'($urandom_range(0, 32'h7FF));
                1:       a = re[k];
                2:       a = $urandom;
                default: a = rs[k];
            endcase
            xfer($sformatf("rand%0d", n), a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
